// File: rtl/ctrl_fsm_v2.sv
// ctrl_fsm_v2 - multi-cycle RV32I control unit.
// Sequences fetch/decode/execute/memory/writeback over a shared-memory
// datapath, tolerates memory wait states up to MEM_TIMEOUT cycles per access,
// and latches the reason the core halted.
// Build option: define CTRL_SYSTEM_EN to stop on ECALL/EBREAK with cause 11;
// otherwise the SYSTEM opcode is treated as illegal (cause 01).
module ctrl_fsm_v2 #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TO_W        = 8,
    parameter int unsigned DBG_W       = 4
) (
    input  logic             clk,
    input  logic             sys_rst_n,
    input  logic [31:0]      instr,
    input  logic             cmp_true,
    input  logic             mem_rdy,
    output logic             valid,
    output logic             adrSrc,
    output logic             mem_we,
    output logic             irWrite,
    output logic             pcWrite,
    output logic [1:0]       resultSrc,
    output logic [1:0]       aluSrcA,
    output logic [1:0]       aluSrcB,
    output logic [3:0]       aluCtr,
    output logic [1:0]       comCtr,
    output logic [2:0]       immSrc,
    output logic             reg_w,
    output logic             halt,
    output logic [1:0]       halt_cause,
    output logic [DBG_W-1:0] debug_port
);

    typedef enum logic [3:0] {
        ST_RST    = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_EXE_R  = 4'd7,
        ST_EXE_I  = 4'd8,
        ST_ALUWB  = 4'd9,
        ST_BRANCH = 4'd10,
        ST_JALR_A = 4'd11,
        ST_JAL    = 4'd12,
        ST_UPPER  = 4'd13,
        ST_HALT   = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
    localparam logic [1:0] CAUSE_SYSTEM  = 2'b11;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic            TO_EN    = (MEM_TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

    state_t          state_q;
    state_t          state_d;
    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;
    logic [1:0]      cause_q;
    logic [1:0]      cause_d;

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic       alt_s;
    logic       mem_acc_s;
    logic       timeout_s;
    logic       unused_instr_s;

    assign opcode_s = instr[6:0];
    assign funct3_s = instr[14:12];
    assign alt_s    = instr[30];
    assign unused_instr_s = ^{instr[31], instr[29:15], instr[11:7]};

    // States that drive a memory request and may therefore wait on mem_rdy.
    assign mem_acc_s = (state_q == ST_FETCH) || (state_q == ST_MEMRD) ||
                       (state_q == ST_MEMWR);
    // Limit reached and memory still silent; a late mem_rdy on this cycle wins.
    assign timeout_s = TO_EN && mem_acc_s && !mem_rdy && (cnt_q == TO_LIMIT);

    // State, wait counter and halt cause registers.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_RST;
            cnt_q   <= '0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    // Next-state selection and halt cause capture.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            ST_RST: state_d = ST_FETCH;
            ST_FETCH: begin
                if (mem_rdy) begin
                    state_d = ST_DECODE;
                end else if (timeout_s) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                case (opcode_s)
                    OP_LOAD, OP_STORE: state_d = ST_MEMADR;
                    OP_R:              state_d = ST_EXE_R;
                    OP_I:              state_d = ST_EXE_I;
                    OP_BRANCH:         state_d = ST_BRANCH;
                    OP_JAL:            state_d = ST_JAL;
                    OP_JALR:           state_d = ST_JALR_A;
                    OP_LUI, OP_AUIPC:  state_d = ST_UPPER;
                    OP_SYSTEM: begin
                        state_d = ST_HALT;
`ifdef CTRL_SYSTEM_EN
                        cause_d = CAUSE_SYSTEM;
`else
                        cause_d = CAUSE_ILLEGAL;
`endif
                    end
                    default: begin
                        state_d = ST_HALT;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            ST_MEMADR: begin
                if (opcode_s == OP_LOAD) begin
                    state_d = ST_MEMRD;
                end else begin
                    state_d = ST_MEMWR;
                end
            end
            ST_MEMRD: begin
                if (mem_rdy) begin
                    state_d = ST_MEMWB;
                end else if (timeout_s) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    state_d = ST_MEMRD;
                end
            end
            ST_MEMWR: begin
                if (mem_rdy) begin
                    state_d = ST_FETCH;
                end else if (timeout_s) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    state_d = ST_MEMWR;
                end
            end
            ST_MEMWB:  state_d = ST_FETCH;
            ST_EXE_R:  state_d = ST_ALUWB;
            ST_EXE_I:  state_d = ST_ALUWB;
            ST_ALUWB:  state_d = ST_FETCH;
            ST_BRANCH: begin
                // funct3 010/011 are not RV32I branches.
                if (funct3_s[2:1] == 2'b01) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_JALR_A: state_d = ST_JAL;
            ST_JAL:    state_d = ST_ALUWB;
            ST_UPPER:  state_d = ST_ALUWB;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_RST;
        endcase
    end

    // Wait counter: counts stalled request cycles, cleared on completion or state change.
    always_comb begin
        if (mem_acc_s && !mem_rdy && (state_d == state_q) && (cnt_q != '1)) begin
            cnt_d = cnt_q + TO_W'(1);
        end else begin
            cnt_d = '0;
        end
    end

    // Datapath control decode from the current state and instruction fields.
    always_comb begin
        valid     = 1'b0;
        adrSrc    = 1'b0;
        mem_we    = 1'b0;
        irWrite   = 1'b0;
        pcWrite   = 1'b0;
        resultSrc = 2'b00;
        aluSrcA   = 2'b00;
        aluSrcB   = 2'b00;
        aluCtr    = 4'b0000;
        comCtr    = 2'b00;
        immSrc    = IMM_I;
        reg_w     = 1'b0;
        halt      = 1'b0;
        case (state_q)
            ST_FETCH: begin
                valid     = 1'b1;
                aluSrcB   = 2'b10;
                resultSrc = 2'b10;
                irWrite   = mem_rdy;
                pcWrite   = mem_rdy;
            end
            ST_DECODE: begin
                // Speculative branch/jump target oldPC + imm into aluOut.
                aluSrcA = 2'b01;
                aluSrcB = 2'b01;
                immSrc  = (opcode_s == OP_JAL) ? IMM_J : IMM_B;
            end
            ST_MEMADR: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
                immSrc  = (opcode_s == OP_LOAD) ? IMM_I : IMM_S;
            end
            ST_MEMRD: begin
                valid  = 1'b1;
                adrSrc = 1'b1;
            end
            ST_MEMWB: begin
                resultSrc = 2'b01;
                reg_w     = 1'b1;
            end
            ST_MEMWR: begin
                valid  = 1'b1;
                adrSrc = 1'b1;
                mem_we = 1'b1;
            end
            ST_EXE_R: begin
                aluSrcA = 2'b10;
                aluCtr  = {alt_s, funct3_s};
            end
            ST_EXE_I: begin
                // Only SRAI uses funct7[5]; for other I-ops it is immediate data.
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
                aluCtr  = {alt_s & (funct3_s == 3'b101), funct3_s};
            end
            ST_ALUWB: begin
                reg_w = 1'b1;
            end
            ST_BRANCH: begin
                aluSrcA = 2'b10;
                comCtr  = funct3_s[2:1];
                pcWrite = cmp_true ^ funct3_s[0];
            end
            ST_JALR_A: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
            end
            ST_JAL: begin
                // Target already in aluOut; ALU now forms the link value oldPC + 4.
                pcWrite = 1'b1;
                aluSrcA = 2'b01;
                aluSrcB = 2'b10;
            end
            ST_UPPER: begin
                immSrc  = IMM_U;
                aluSrcB = 2'b01;
                aluSrcA = (opcode_s == OP_LUI) ? 2'b11 : 2'b01;
            end
            ST_HALT: begin
                halt = 1'b1;
            end
            default: begin
                halt = 1'b0;
            end
        endcase
    end

    assign halt_cause = cause_q;
    assign debug_port = DBG_W'(state_q);

endmodule
